// File: rtl/pingpong_clear_ram_if.sv
// Bus bundle for pingpong_clear_ram: write port, registered read port and swap handshake.
// The master drives the requests; the RAM (slave) returns read data and status.
interface pingpong_clear_ram_if #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  active_bank;
  logic                  clear_busy;

  modport master (
    output we, write_addr, write_data, read_addr, swap_req,
    input  read_data, swap_ack, active_bank, clear_busy
  );

  modport slave (
    input  we, write_addr, write_data, read_addr, swap_req,
    output read_data, swap_ack, active_bank, clear_busy
  );
endinterface

// File: rtl/pingpong_clear_ram.sv
// Double-buffered occupancy RAM: the active bank serves user traffic while the shadow bank is
// swept to CLEAR_VALUE; swaps are accepted only once the shadow bank is clean.
module pingpong_clear_ram #(
  parameter int unsigned           DATA_WIDTH  = 1,
  parameter int unsigned           DEPTH       = 1024,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic                 clk,
  input logic                 reset,
  pingpong_clear_ram_if.slave bus
);

  localparam int unsigned           IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {StInit, StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                  active_bank_q, active_bank_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  swap_ack_q, swap_ack_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  logic                  we0, we1;
  logic [IdxW-1:0]       idx0, idx1;
  logic [DATA_WIDTH-1:0] wd0, wd1;

  logic            wr_in_range, rd_in_range, user_we, sweep_done, shadow_bank;
  logic [IdxW-1:0] wr_idx, rd_idx, clear_idx;

  assign wr_in_range = {1'b0, bus.write_addr} < DepthExt;
  assign rd_in_range = {1'b0, bus.read_addr} < DepthExt;
  assign wr_idx      = bus.write_addr[IdxW-1:0];
  assign rd_idx      = bus.read_addr[IdxW-1:0];
  assign clear_idx   = clear_addr_q[IdxW-1:0];
  assign user_we     = bus.we && wr_in_range;
  assign sweep_done  = (clear_addr_q == LastAddr);
  assign shadow_bank = ~active_bank_q;

  always_comb begin
    state_d        = state_q;
    clear_addr_d   = clear_addr_q;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    swap_ack_d     = 1'b0;
    we0            = 1'b0;
    we1            = 1'b0;
    idx0           = wr_idx;
    idx1           = wr_idx;
    wd0            = bus.write_data;
    wd1            = bus.write_data;

    // Sweep progression and request latching are shared by INIT and CLEAR.
    if (state_q != StReady) begin
      if (bus.swap_req) swap_pending_d = 1'b1;
      if (sweep_done) begin
        state_d      = StReady;
        clear_addr_d = '0;
      end else begin
        clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      StInit: begin
        we0  = 1'b1;
        we1  = 1'b1;
        idx0 = clear_idx;
        idx1 = clear_idx;
        wd0  = CLEAR_VALUE;
        wd1  = CLEAR_VALUE;
      end
      StClear: begin
        if (shadow_bank) begin
          we1  = 1'b1;
          idx1 = clear_idx;
          wd1  = CLEAR_VALUE;
          we0  = user_we;
        end else begin
          we0  = 1'b1;
          idx0 = clear_idx;
          wd0  = CLEAR_VALUE;
          we1  = user_we;
        end
      end
      StReady: begin
        // A write in the acceptance cycle still lands in the pre-toggle bank.
        if (active_bank_q) we1 = user_we;
        else               we0 = user_we;
        if (bus.swap_req || swap_pending_q) begin
          active_bank_d  = ~active_bank_q;
          swap_ack_d     = 1'b1;
          state_d        = StClear;
          clear_addr_d   = '0;
          swap_pending_d = 1'b0;
        end
      end
      default: begin
        state_d      = StInit;
        clear_addr_d = '0;
      end
    endcase
  end

  always_comb begin
    read_data_d = CLEAR_VALUE;
    if (state_q != StInit && rd_in_range) begin
      read_data_d = active_bank_q ? mem1[rd_idx] : mem0[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StInit;
      clear_addr_q   <= '0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
      read_data_q    <= CLEAR_VALUE;
    end else begin
      state_q        <= state_d;
      clear_addr_q   <= clear_addr_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      swap_ack_q     <= swap_ack_d;
      read_data_q    <= read_data_d;
    end
  end

  // Storage carries no reset; INIT overwrites every entry before any read is served.
  always_ff @(posedge clk) begin
    if (we0) mem0[idx0] <= wd0;
    if (we1) mem1[idx1] <= wd1;
  end

  assign bus.read_data   = read_data_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.active_bank = active_bank_q;
  assign bus.clear_busy  = (state_q != StReady);

endmodule
